// File: rtl/stream_pkg.sv
// stream_pkg: shared constants and keep-mask helper for the stream packer
//   WIDTH_D / RATIO_D  default beat width and beats per word
//   keep_mask(n)       contiguous mask with the low n bits set
package stream_pkg;
    localparam int WIDTH_D = 8;
    localparam int RATIO_D = 4;
    localparam int MASK_W  = 32;

    function automatic logic [MASK_W-1:0] keep_mask(input int n);
        return n >= MASK_W ? '1 : (MASK_W'(1) << n) - MASK_W'(1);
    endfunction
endpackage

// File: rtl/stream_packer.sv
// stream_packer: packs ratio_p width_p-bit beats into one wide word
//   clk_i, reset_i              clock, synchronous active-high reset
//   data_i/valid_i/last_i/ready_o  input beat handshake; last_i closes a word early
//   data_o/keep_o/last_o/valid_o/ready_i  output word handshake; keep_o marks filled slots
module stream_packer
    import stream_pkg::*;
#(
    parameter int width_p = WIDTH_D,
    parameter int ratio_p = RATIO_D
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic                       ready_o,
    output logic [ratio_p*width_p-1:0] data_o,
    output logic [ratio_p-1:0]         keep_o,
    output logic                       last_o,
    output logic                       valid_o,
    input  logic                       ready_i
);
    localparam int cnt_w = $clog2(ratio_p);

    logic [cnt_w-1:0]           cnt;
    logic [ratio_p*width_p-1:0] acc;
    logic [ratio_p*width_p-1:0] packed_word;
    logic                       take;
    logic                       close;

    assign ready_o = !valid_o || ready_i;
    assign take    = valid_i && ready_o;
    assign close   = take && (last_i || cnt == cnt_w'(ratio_p - 1));

    // Accumulator with the incoming beat merged into its slot, so a closing
    // beat reaches the output register in the same edge it is accepted.
    always_comb begin
        packed_word = acc;
        packed_word[int'(cnt)*width_p +: width_p] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt     <= '0;
            acc     <= '0;
            data_o  <= '0;
            keep_o  <= '0;
            last_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            if (close) begin
                data_o  <= packed_word;
                keep_o  <= ratio_p'(keep_mask(int'(cnt) + 1));
                last_o  <= last_i;
                valid_o <= 1'b1;
                cnt     <= '0;
                acc     <= '0;
            end else if (take) begin
                acc <= packed_word;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: scoreboard bench for stream_packer
module tb_stream_packer;
    localparam int W = 8;
    localparam int R = 4;

    typedef struct {
        logic [R*W-1:0] d;
        logic [R-1:0]   k;
        logic           l;
    } word_t;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   data_i = '0;
    logic           valid_i = 1'b0;
    logic           last_i = 1'b0;
    logic           ready_o;
    logic [R*W-1:0] data_o;
    logic [R-1:0]   keep_o;
    logic           last_o;
    logic           valid_o;
    logic           ready_i = 1'b0;

    word_t exp_q[$];
    beat_t src_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_out = -1;
    int nwords = 0;
    bit gap_on = 0;
    logic [R*W-1:0] acc = '0;
    int cnt = 0;

    stream_packer #(.width_p(W), .ratio_p(R)) dut (
        .clk_i(clk), .reset_i(reset),
        .data_i(data_i), .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o),
        .data_o(data_o), .keep_o(keep_o), .last_o(last_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic l);
        src_q.push_back('{d, l});
    endtask

    // Drive one cycle, sample 1 time unit before the rising edge, update the model.
    task automatic step(input bit gate, input bit rdy, input bit hold_chk);
        word_t w;
        beat_t b;
        valid_i = gate && src_q.size() > 0;
        data_i  = valid_i ? src_q[0].d : '0;
        last_i  = valid_i ? src_q[0].l : 1'b0;
        ready_i = rdy;
        #4;
        chk("ready", 32'(ready_o), 32'(!valid_o || ready_i));
        if (hold_chk && valid_o && !ready_i && exp_q.size() > 0) begin
            chk("hold_data", data_o, exp_q[0].d);
            chk("hold_keep", 32'(keep_o), 32'(exp_q[0].k));
        end
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("spurious", 1, 0);
            else begin
                w = exp_q.pop_front();
                chk("data", data_o, w.d);
                chk("keep", 32'(keep_o), 32'(w.k));
                chk("last", 32'(last_o), 32'(w.l));
                if (gap_on && last_out >= 0) chk("gap", 32'(cyc - last_out), 4);
                last_out = cyc;
                nwords++;
            end
        end
        if (valid_i && ready_o) begin
            b = src_q.pop_front();
            acc[cnt*W +: W] = b.d;
            cnt++;
            if (b.l || cnt == R) begin
                exp_q.push_back('{acc, R'((1 << cnt) - 1), b.l});
                acc = '0;
                cnt = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && (exp_q.size() > 0 || src_q.size() > 0); i++) step(1, 1, 0);
        chk(tag, 32'(exp_q.size() + src_q.size()), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_i = 1'b0;
        #4;
        @(negedge clk);
        reset = 1'b0;
        acc = '0;
        cnt = 0;
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        int n0;
        do_reset();
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_keep", 32'(keep_o), 0);
        chk("rst_last", 32'(last_o), 0);
        chk("rst_data", data_o, 0);
        chk("rst_ready", 32'(ready_o), 1);

        n0 = nwords;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        exp_q.delete();
        drain("t1_drain");
        chk("t1_words", 32'(nwords - n0), 1);

        n0 = nwords;
        push(8'hAA, 0); push(8'hBB, 1);
        drain("t2_drain");
        chk("t2_words", 32'(nwords - n0), 1);

        n0 = nwords;
        for (int i = 1; i <= 12; i++) push(W'(i), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1);
        chk("t3_held", 32'(src_q.size()), 8);
        drain("t3_drain");
        chk("t3_words", 32'(nwords - n0), 3);

        n0 = nwords;
        for (int i = 0; i < 40; i++) push(W'(8'h40 + i), 0);
        gap_on = 1;
        last_out = -1;
        drain("t4_drain");
        gap_on = 0;
        chk("t4_words", 32'(nwords - n0), 10);

        push(8'hE1, 0); push(8'hE2, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        do_reset();
        chk("t5_valid", 32'(valid_o), 0);
        chk("t5_keep", 32'(keep_o), 0);
        n0 = nwords;
        push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0);
        drain("t5_drain");
        chk("t5_words", 32'(nwords - n0), 1);

        for (int i = 0; i < 200; i++) push(W'($urandom), $urandom_range(0, 4) == 0);
        for (int i = 0; i < 2000 && src_q.size() > 0; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, 1);
        chk("t6_src", 32'(src_q.size()), 0);
        push(8'hF0, 1);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
